// File: rtl/tiny_dnn_pkg.sv
// Shared constants and state type for the tiny_dnn neuron sequencer.
package tiny_dnn_pkg;

   localparam int F_SIZE = 512;
   localparam int AW     = $clog2(F_SIZE);

   // Weight-memory slot that holds the bias.
   localparam logic [AW-1:0] bias_adr = AW'(F_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_INIT,
      S_EXEC,
      S_BIAS,
      S_DRAIN0,
      S_DRAIN1,
      S_DONE
   } ctrl_state_t;

endpackage

// File: rtl/tiny_dnn_ctrl.sv
// Load/run sequencer for one tiny_dnn_core neuron: issues the core strobes,
// the core address and the activation-buffer address; carries no data.
module tiny_dnn_ctrl #(
   parameter int F_SIZE = tiny_dnn_pkg::F_SIZE,
   parameter int AW     = tiny_dnn_pkg::AW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] n_in,
   input  logic          load_start,
   input  logic          run_start,
   input  logic          wvalid,
   output logic          wready,
   input  logic          out_ready,
   output logic          out_valid,
   output logic          busy,
   output logic          init,
   output logic          write,
   output logic          bwrite,
   output logic          exec,
   output logic          bias,
   output logic [AW-1:0] a,
   output logic [AW-1:0] src_adr
);
   import tiny_dnn_pkg::*;

   localparam logic [AW-1:0] LAST_ADR = AW'(F_SIZE - 1);

   ctrl_state_t   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] n_lat_q, n_lat_d;
   logic [AW-1:0] n_sat;
   logic          last_word;

   assign n_sat     = (32'(n_in) > F_SIZE - 1) ? LAST_ADR : n_in;
   assign last_word = (cnt_q == n_lat_q);

   // NOTE: the reset branch is asynchronous and every register is cleared in it;
   // sequential state uses non-blocking assignments only, so all flops update
   // together on the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         n_lat_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_lat_q <= n_lat_d;
      end
   end

   // NOTE: every variable gets a default before the case, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_lat_d = n_lat_q;
      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               n_lat_d = n_sat;
            end else if (run_start) begin
               state_d = S_INIT;
               n_lat_d = n_sat;
            end
         end
         S_LOAD: begin
            if (wvalid) begin
               if (last_word) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_INIT: begin
            cnt_d   = '0;
            state_d = (n_lat_q == '0) ? S_BIAS : S_EXEC;
         end
         S_EXEC: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == n_lat_q - 1'b1) state_d = S_BIAS;
         end
         S_BIAS:   state_d = S_DRAIN0;
         S_DRAIN0: state_d = S_DRAIN1;
         S_DRAIN1: state_d = S_DONE;
         S_DONE:   if (out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Write path is combinational so the core captures wd on the handshake edge.
   always_comb begin
      wready    = (state_q == S_LOAD);
      write     = (state_q == S_LOAD) && wvalid;
      bwrite    = (state_q == S_LOAD) && wvalid && last_word;
      init      = (state_q == S_INIT);
      exec      = (state_q == S_EXEC);
      bias      = (state_q == S_BIAS);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      a         = '0;
      src_adr   = '0;
      case (state_q)
         S_LOAD: a = last_word ? LAST_ADR : cnt_q;
         S_EXEC: begin
            a       = cnt_q;
            src_adr = cnt_q;
         end
         S_BIAS:  a = LAST_ADR;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tiny_dnn_ctrl.sv
// Self-checking bench for tiny_dnn_ctrl: cycle schedule checks plus an
// integer core/activation-buffer model whose final sum is compared to a dot product.
module tb_tiny_dnn_ctrl;
   import tiny_dnn_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] n_in = '0;
   logic          load_start = 1'b0, run_start = 1'b0, wvalid = 1'b0, out_ready = 1'b0;
   logic          wready, out_valid, busy, init, write, bwrite, exec, bias;
   logic [AW-1:0] a, src_adr;

   int n_checks = 0;
   int n_fail   = 0;

   tiny_dnn_ctrl dut (
      .clk(clk), .rst_n(rst_n), .n_in(n_in), .load_start(load_start),
      .run_start(run_start), .wvalid(wvalid), .wready(wready),
      .out_ready(out_ready), .out_valid(out_valid), .busy(busy),
      .init(init), .write(write), .bwrite(bwrite), .exec(exec),
      .bias(bias), .a(a), .src_adr(src_adr)
   );

   always #5 clk = ~clk;

   // Intended weights/activations (fixed-point: value x2, so 0.5 -> 1).
   int ref_w[F_SIZE];
   int ref_bias;
   int act[F_SIZE];

   // Behavioural core and synchronous-read activation buffer driven by the strobes.
   int            wd;
   int            w_mem[F_SIZE];
   int            d_q;
   int            acc;
   logic          exec1, bias1;
   logic [AW-1:0] adr1;

   always @(posedge clk) begin
      d_q   <= act[src_adr];
      if (write) w_mem[a] <= wd;
      exec1 <= exec;
      bias1 <= bias;
      adr1  <= a;
      if (init)       acc <= 0;
      else if (exec1) acc <= acc + w_mem[adr1] * d_q;
      else if (bias1) acc <= acc + w_mem[bias_adr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic int exp_sum(input int n);
      int s = ref_bias;
      for (int i = 0; i < n; i++) s += ref_w[i] * act[i];
      return s;
   endfunction

   task automatic randomize_set(input int n);
      for (int i = 0; i < n; i++) begin
         ref_w[i] = int'($urandom_range(0, 100));
         act[i]   = int'($urandom_range(0, 50));
      end
      ref_bias = int'($urandom_range(0, 200));
   endtask

   task automatic do_load(input int n, input bit gaps, input bit with_run);
      int idx = 0;
      int cyc = 0;
      tick();
      n_in       = AW'(n);
      load_start = 1'b1;
      run_start  = with_run;
      sample();
      check("load_req_idle", busy, 0);
      tick();
      load_start = 1'b0;
      run_start  = 1'b0;
      while (idx <= n && cyc < 4 * n + 40) begin
         wvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         wd     = (idx == n) ? ref_bias : ref_w[idx];
         sample();
         check("load_wready", wready, 1);
         check("load_write", write, wvalid);
         check("load_bwrite", bwrite, (wvalid && idx == n));
         if (wvalid) begin
            check("load_a", a, (idx == n) ? 64'(bias_adr) : 64'(idx));
            idx++;
         end
         cyc++;
         tick();
      end
      wvalid = 1'b0;
      if (idx <= n) check("load_timeout", idx, n + 1);
      if (!gaps) check("load_cycles", cyc, n + 1);
      sample();
      check("load_end_wready", wready, 0);
      check("load_end_busy", busy, 0);
   endtask

   task automatic do_run(input int n, input int hold);
      int exp = exp_sum(n);
      tick();
      n_in      = AW'(n);
      run_start = 1'b1;
      sample();
      check("run_req_busy", busy, 0);
      for (int c = 1; c <= n + 4; c++) begin
         tick();
         run_start = 1'b0;
         sample();
         check("run_init", init, (c == 1));
         check("run_exec", exec, (c >= 2 && c <= n + 1));
         check("run_bias", bias, (c == n + 2));
         check("run_busy", busy, 1);
         check("run_out_valid", out_valid, 0);
         if (c >= 2 && c <= n + 1) begin
            check("run_exec_a", a, c - 2);
            check("run_src_adr", src_adr, c - 2);
         end
         if (c == n + 2) check("run_bias_a", a, bias_adr);
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         run_start = (h == 1);
         out_ready = 1'b0;
         sample();
         check("done_out_valid", out_valid, 1);
         check("done_busy", busy, 1);
         check("done_no_strobe", {init, exec, bias}, 0);
         check("done_sum", acc, exp);
      end
      tick();
      run_start = 1'b0;
      out_ready = 1'b1;
      sample();
      check("hs_out_valid", out_valid, 1);
      check("hs_sum", acc, exp);
      tick();
      out_ready = 1'b0;
      sample();
      check("post_out_valid", out_valid, 0);
      check("post_busy", busy, 0);
   endtask

   initial begin
      sample();
      check("reset_outputs",
            {wready, out_valid, busy, init, write, bwrite, exec, bias, a, src_adr}, 0);
      tick();
      rst_n = 1'b1;

      // Weights 1.0, 2.0, 3.0, bias 0.5; d = 1, 1, 2 -> 9.5 (x2 = 19).
      ref_w[0] = 2; ref_w[1] = 4; ref_w[2] = 6; ref_bias = 1;
      act[0] = 1; act[1] = 1; act[2] = 2;
      do_load(3, 1'b0, 1'b0);
      check("fixed_sum_model", exp_sum(3), 19);
      do_run(3, 5);

      // Zero inputs: bias only.
      ref_bias = 1;
      do_load(0, 1'b0, 1'b0);
      do_run(0, 0);

      // Random sizes, random wvalid gaps; the first load also asserts run_start.
      for (int it = 0; it < 3; it++) begin
         int n = int'($urandom_range(1, 20));
         randomize_set(n);
         do_load(n, 1'b1, it == 0);
         do_run(n, int'($urandom_range(0, 3)));
      end

      // Reset in the last EXEC cycle, then a fresh load and run.
      randomize_set(6);
      do_load(6, 1'b0, 1'b0);
      tick();
      n_in      = AW'(6);
      run_start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         tick();
         run_start = 1'b0;
      end
      check("pre_reset_exec", exec, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {wready, out_valid, busy, init, write, bwrite, exec, bias, a, src_adr}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      sample();
      check("post_reset_busy", busy, 0);
      randomize_set(5);
      do_load(5, 1'b1, 1'b0);
      do_run(5, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tiny_dnn_ctrl.md
# tiny_dnn_ctrl

Sequencer for one `tiny_dnn_core` neuron. It drives the core's `init`, `write`, `bwrite`, `exec`, `bias` and `a` strobes through two phases:

- **Load:** a weight stream of `n_in` weights plus one bias is written into the core.
- **Run:** `init`, `n_in` multiply-accumulate cycles and the bias add are issued, then the result is presented with a valid/ready handshake.

The controller carries no numeric data. Weights (`wd`) and activations (`d`) go to the core directly; the controller supplies the handshakes and the activation-buffer address.

## Interface
Parameters:
- `F_SIZE`, 512: depth of the core weight memory. Slot `F_SIZE-1` is reserved for the bias.
- `AW`, 9: address width, `$clog2(F_SIZE)`.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `n_in` in AW: number of inputs. Sampled on an accepted `load_start` or `run_start`. Values above `F_SIZE-1` saturate to `F_SIZE-1`.
- `load_start` in 1: single-cycle request to enter the weight load phase.
- `run_start` in 1: single-cycle request to run one dot product.
- `wvalid` in 1: weight-stream word valid; `wd` is driven to the core by the source.
- `wready` out 1: weight-stream ready.
- `out_ready` in 1: the consumer accepts the core `sum`.
- `out_valid` out 1: the core `sum` is final and stable.
- `busy` out 1: the controller is not in IDLE.
- `init`, `write`, `bwrite`, `exec`, `bias` out 1 each: core strobes.
- `a` out AW: core address.
- `src_adr` out AW: activation-buffer read address. The buffer has synchronous read, so `d` is valid one cycle after `src_adr`.

## Operation
States: IDLE, LOAD, INIT, EXEC, BIAS, DRAIN0, DRAIN1, DONE. A counter `cnt` of width AW and the latched `n_lat` support the sequence.

- **IDLE:** all strobes are 0.
  - `load_start` → LOAD with `cnt=0`.
  - Otherwise `run_start` → INIT.
  - If both are asserted, load wins.
  - A start of either kind outside IDLE is ignored.
- **LOAD:** `wready=1`. On each `wvalid&wready` cycle, `write=1` and `a=cnt`, then `cnt++`.
  - When `cnt==n_lat`, the accepted word is the bias: `write=1`, `bwrite=1`, `a=F_SIZE-1`, and the next state is IDLE.
  - `wvalid=0` stalls with no strobes.
- **INIT:** `init=1` for one cycle, `cnt=0`.
  - Next state is EXEC, or BIAS when `n_lat==0`.
- **EXEC:** `exec=1`, `a=src_adr=cnt`, `cnt++`.
  - After the cycle with `cnt==n_lat-1`, the next state is BIAS. There are no bubbles.
- **BIAS:** `bias=1`, `a=F_SIZE-1`, one cycle.
- **DRAIN0, DRAIN1:** cover the core's one-cycle `w` fetch and its accumulate register.
- **DONE:** `out_valid=1`, held until `out_ready`, then IDLE.
  - The core `sum` is unchanged while in DONE because no `init`, `exec` or `bias` is issued.
- **Reset:** asynchronous reset in any state returns to IDLE with `cnt=0` and `n_lat=0`.
  - Every output resets to 0, including `wready`, `out_valid`, `busy` and `a`.
  - A partially loaded weight set stays in the core and is not valid. Software must reload it.

## Timing
- All outputs except `write`, `bwrite` and `a` in LOAD are registered state decodes.
  - In LOAD, `write=wvalid` and `a` is combinational from `cnt`, so the core captures `wd` on the same edge as the handshake.
- Run latency from an accepted `run_start` in cycle 0, for `n_in=N>0`:
  - INIT in cycle 1.
  - EXEC in cycles 2..N+1.
  - BIAS in cycle N+2.
  - DRAIN in cycles N+3 and N+4.
  - `out_valid` from cycle N+5.
  - `busy` is high from cycle 1 through the `out_ready` cycle.
- For `N=0`: INIT in cycle 1, BIAS in cycle 2, `out_valid` from cycle 5.
- The activation for address k is presented by the buffer in the cycle after EXEC with `a=k`. This matches the core's `exec1` accumulate.
- Load takes `N+1` accepted words. With `wvalid` held high, LOAD lasts exactly `N+1` cycles.
- `out_valid&out_ready` in cycle t puts the controller in IDLE in cycle t+1. A new `run_start` is accepted from cycle t+1.

## Structure
- Package `tiny_dnn_pkg` holds `F_SIZE`, `AW`, the `bias_adr = F_SIZE-1` constant and the `ctrl_state_t` enum.
- The block is a single module with no sub-module. The counter and the state machine live in `tiny_dnn_ctrl`.
- The top level instantiates it next to one `tiny_dnn_core`, with `src_adr` driving the activation RAM.

## Test plan
- **Load, `n_in=3`:** stream 1.0, 2.0, 3.0, 0.5 with `wvalid` held → `write` on 4 consecutive cycles at `a`=0, 1, 2, then `bwrite` with `a=511`; `wready` drops after the fourth word.
- **Run, `n_in=3`:** d=[1,1,2] → `exec` in cycles 2..4, `bias` in cycle 5, `out_valid` in cycle 8, `sum=9.5`.
- **`out_ready` held low for 5 cycles:** `out_valid` and `sum` are stable; a `run_start` during DONE is ignored.
- **`n_in=0`:** load takes a single `bwrite` word (0.5) → run has no `exec`, `out_valid` in cycle 5, `sum=0.5`.
- **Random `wvalid` gaps during load:** strobes appear only on handshake cycles and the addresses are contiguous. `load_start` and `run_start` in the same cycle → LOAD.
- **Reset:** `rst_n` low in cycle N+1 of an EXEC burst → all outputs 0 immediately. After release, the controller is in IDLE and a fresh load plus run gives the correct `sum`.
